// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer: FSM state encoding,
// default data memory fill word and the sweep address widths.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REGS,
      BPRED,
      DMEM,
      DONE
   } boot_state_t;

   localparam logic [31:0] DMEM_FILL_DEFAULT = 32'hefefefef;

   localparam int unsigned RF_AW = 5;
   localparam int unsigned BP_AW = 10;
   localparam int unsigned DM_AW = 18;

endpackage : boot_pkg

// File: rtl/boot_seq.sv
// Boot sequencer: after reset, sweeps the register file, predictor/BTB and
// data memory with initial values, holding the core in reset until done.
module boot_seq
   import boot_pkg::*;
#(
   parameter int unsigned REG_COUNT    = 32,
   parameter int unsigned BP_DEPTH     = 1024,
   parameter logic [31:0] DMEM_DEPTH   = 32'h40000,
   parameter logic [31:0] DMEM_FILL    = DMEM_FILL_DEFAULT,
   parameter bit          PRELOAD_REGS = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rerun,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             bp_we,
   output logic [BP_AW-1:0] bp_waddr,
   output logic             dm_we,
   output logic [DM_AW-1:0] dm_waddr,
   output logic [31:0]      dm_wdata,
   input  logic             dm_ready,
   output logic             cpu_hold,
   output logic             boot_done
);

   localparam logic [DM_AW-1:0] RF_LAST = DM_AW'(REG_COUNT - 1);
   localparam logic [DM_AW-1:0] BP_LAST = DM_AW'(BP_DEPTH - 1);
   localparam logic [DM_AW-1:0] DM_LAST = DM_AW'(DMEM_DEPTH - 32'd1);

   boot_state_t      r_state;
   logic [DM_AW-1:0] r_idx;
   logic [1:0]       r_mod3;

   boot_state_t      w_state_nxt;
   logic [DM_AW-1:0] w_idx_nxt;
   logic [1:0]       w_mod3_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_mod3  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_mod3  <= w_mod3_nxt;
      end
   end

   assign dm_wdata = DMEM_FILL;

   // Outputs decode only r_state/r_idx/r_mod3; dm_ready feeds the next-state path alone.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mod3_nxt  = r_mod3;
      rf_we       = 1'b0;
      bp_we       = 1'b0;
      dm_we       = 1'b0;
      rf_waddr    = r_idx[RF_AW-1:0];
      bp_waddr    = r_idx[BP_AW-1:0];
      dm_waddr    = r_idx;
      rf_wdata    = '0;
      cpu_hold    = 1'b1;
      boot_done   = 1'b0;

      case (r_state)
         IDLE: begin
            w_state_nxt = REGS;
            w_idx_nxt   = '0;
            w_mod3_nxt  = '0;
         end
         REGS: begin
            rf_we = 1'b1;
            if (PRELOAD_REGS)
               rf_wdata = {9'b0, r_idx, 5'b0} + {30'b0, r_mod3};
            if (r_idx == RF_LAST) begin
               w_state_nxt = BPRED;
               w_idx_nxt   = '0;
               w_mod3_nxt  = '0;
            end else begin
               w_idx_nxt  = r_idx + 1'b1;
               w_mod3_nxt = (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
            end
         end
         BPRED: begin
            bp_we = 1'b1;
            if (r_idx == BP_LAST) begin
               w_state_nxt = DMEM;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         DMEM: begin
            dm_we = 1'b1;
            if (dm_ready) begin
               if (r_idx == DM_LAST) begin
                  w_state_nxt = DONE;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         DONE: begin
            cpu_hold  = 1'b0;
            boot_done = 1'b1;
            if (rerun) begin
               w_state_nxt = REGS;
               w_idx_nxt   = '0;
               w_mod3_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_mod3_nxt  = '0;
         end
      endcase
   end

endmodule : boot_seq
